// File: rtl/async_rr_arbiter.sv
// Round-robin mutual-exclusion arbiter with per-bit request synchronisers.
// Owners hold the grant until they drop their request; the search then resumes after the last owner.
module async_rr_arbiter #(
  parameter int REQUESTORS  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REQUESTORS-1:0] request,
  output logic [REQUESTORS-1:0] grant
);

  localparam int LAST_W = $clog2(REQUESTORS);
  localparam logic [LAST_W-1:0] LAST_RST = LAST_W'(REQUESTORS - 1);

  logic [REQUESTORS-1:0] req_s;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign req_s = request;
    end else begin : g_sync
      logic [REQUESTORS-1:0] sync_q [SYNC_STAGES];
      logic [REQUESTORS-1:0] sync_d [SYNC_STAGES];

      always_comb begin
        sync_d[0] = request;
        for (int s = 1; s < SYNC_STAGES; s++) begin
          sync_d[s] = sync_q[s-1];
        end
      end

      always_ff @(posedge clk) begin
        for (int s = 0; s < SYNC_STAGES; s++) begin
          if (rst) sync_q[s] <= '0;
          else     sync_q[s] <= sync_d[s];
        end
      end

      assign req_s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  logic [REQUESTORS-1:0] grant_q, grant_d;
  logic [LAST_W-1:0]     last_q, last_d;
  logic                  hold;
  logic                  found;
  int                    idx;

  // Arbitration: the holder keeps the grant while its synchronised request stays high.
  always_comb begin
    grant_d = grant_q;
    last_d  = last_q;
    found   = 1'b0;
    idx     = 0;
    hold    = |(grant_q & req_s);
    if (!hold) begin
      grant_d = '0;
      // Starting at last+1 makes the previous owner the final candidate.
      for (int off = 1; off <= REQUESTORS; off++) begin
        idx = (int'(last_q) + off) % REQUESTORS;
        if (!found && req_s[idx]) begin
          found        = 1'b1;
          grant_d[idx] = 1'b1;
          last_d       = LAST_W'(idx);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q <= '0;
      last_q  <= LAST_RST;
    end else begin
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  assign grant = grant_q;

endmodule

// File: tb/tb_async_rr_arbiter.sv
// Bench for async_rr_arbiter: directed test-plan sequences plus randomised traffic,
// each cycle compared against a queued reference prediction.
module tb_async_rr_arbiter;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] request = '0;
  logic [N-1:0] grant;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state: two-stage synchroniser, grant and last owner.
  logic [N-1:0] m_s1, m_s2, m_gnt, m_sampled;
  int           m_last;
  logic [N-1:0] exp_q [$];

  async_rr_arbiter #(.REQUESTORS(N), .SYNC_STAGES(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .request (request),
    .grant   (grant)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  // Predict the grant produced by the coming edge from the pre-edge state.
  task automatic model_edge(input logic [N-1:0] r, input logic rs);
    logic [N-1:0] nxt;
    if (rs) begin
      m_s1 = '0; m_s2 = '0; m_gnt = '0; m_last = N - 1; m_sampled = '1;
    end else begin
      m_sampled = m_s2;
      if ((m_gnt & m_s2) != 0) begin
        nxt = m_gnt;
      end else begin
        nxt = '0;
        for (int i = 1; i <= N; i++) begin
          int k;
          k = (m_last + i) % N;
          if (m_s2[k]) begin
            nxt    = N'(1) << k;
            m_last = k;
            break;
          end
        end
      end
      m_gnt = nxt;
      m_s2  = m_s1;
      m_s1  = r;
    end
    exp_q.push_back(m_gnt);
  endtask

  task automatic step(input logic [N-1:0] r, input logic rs = 1'b0);
    logic [N-1:0] e;
    request = r;
    rst     = rs;
    model_edge(r, rs);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("model", 32'(grant), 32'(e));
    check("onehot", 32'($countones(grant) <= 1), 32'd1);
    check("gnt_req", 32'(grant & ~m_sampled), 32'd0);
  endtask

  task automatic run(input logic [N-1:0] r, input int n);
    for (int i = 0; i < n; i++) step(r);
  endtask

  // Step with r until grant differs from prev; an expired budget counts as a failure.
  task automatic wait_change(input logic [N-1:0] r, input logic [N-1:0] prev, input string tag);
    int cyc;
    cyc = 0;
    while (grant == prev && cyc < 12) begin
      step(r);
      cyc++;
    end
    if (grant == prev) check({tag, "_timeout"}, 32'(cyc), 32'd0);
  endtask

  initial begin
    logic [N-1:0] r;
    logic [N-1:0] prev;

    // Reset and idle.
    step('0, 1'b1);
    step('0, 1'b1);
    check("rst_grant", 32'(grant), 32'h00);
    for (int i = 0; i < 4; i++) begin
      step('0);
      check("idle", 32'(grant), 32'h00);
    end

    // Latency of 3 edges, then reset mid-grant.
    run(8'h01, 2);
    check("lat_early", 32'(grant), 32'h00);
    step(8'h01);
    check("lat_grant", 32'(grant), 32'h01);
    step(8'h01, 1'b1);
    check("rst_mid", 32'(grant), 32'h00);
    run(8'h01, 3);
    check("regrant", 32'(grant), 32'h01);

    // No pre-emption, then handover without a zero cycle.
    run(8'h03, 5);
    check("no_preempt", 32'(grant), 32'h01);
    run(8'h02, 2);
    check("hand_pre", 32'(grant), 32'h01);
    step(8'h02);
    check("hand_02", 32'(grant), 32'h02);

    // Chain.
    run(8'h06, 5);  check("hold_02", 32'(grant), 32'h02);
    run(8'h04, 3);  check("give_04", 32'(grant), 32'h04);
    run(8'h0C, 5);  check("hold_04", 32'(grant), 32'h04);
    run(8'h08, 3);  check("give_08", 32'(grant), 32'h08);
    run(8'h00, 2);  check("rel_pre", 32'(grant), 32'h08);
    step(8'h00);    check("rel_00", 32'(grant), 32'h00);

    // Isolated request and search order from last=5.
    run(8'h20, 3);  check("give_20", 32'(grant), 32'h20);
    run(8'h30, 5);  check("hold_20", 32'(grant), 32'h20);
    run(8'h10, 3);  check("give_10", 32'(grant), 32'h10);
    run(8'h00, 3);  check("rel2_00", 32'(grant), 32'h00);

    // Fairness with wrap-around: start from reset so requester 0 goes first.
    step('0, 1'b1);
    wait_change(8'hFF, 8'h00, "rr_first");
    check("rr_0", 32'(grant), 32'h01);
    for (int k = 1; k <= N; k++) begin
      prev = grant;
      step(8'hFF & ~prev);
      wait_change(8'hFF, prev, "rr");
      check($sformatf("rr_%0d", k), 32'(grant), 32'(N'(1) << (k % N)));
    end

    // Randomised traffic with occasional resets.
    r = '0;
    for (int i = 0; i < 10000; i++) begin
      r = r ^ N'($urandom & $urandom & $urandom);
      step(r, ($urandom_range(0, 999) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
